// File: rtl/heart_zone_encoder.sv
// Heart-rate zone encoder: debounces the pulse-sensor beat line, measures beat
// intervals in ms, averages the last four and drives the 3-wire zone code.
module heart_zone_encoder #(
  parameter int CLK_PER_MS  = 50000,
  parameter int DEB         = 3,
  parameter int MIN_MS      = 250,
  parameter int FAST_MS     = 500,
  parameter int ELEV_MS     = 667,
  parameter int NO_PULSE_MS = 2000
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        pulse_in,
  output logic        heartrate1,
  output logic        heartrate2,
  output logic        heartrate3,
  output logic        beat,
  output logic [11:0] interval_avg,
  output logic        tracking
);

  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

  localparam logic [2:0] CODE_NONE   = 3'b111;
  localparam logic [2:0] CODE_NORMAL = 3'b001;
  localparam logic [2:0] CODE_ELEV   = 3'b011;
  localparam logic [2:0] CODE_FAST   = 3'b000;

  typedef enum logic [1:0] {
    NO_SIGNAL = 2'd0,
    ACQUIRE   = 2'd1,
    TRACK     = 2'd2
  } state_t;

  state_t state, state_next;

  logic          sync1, sync2;
  logic [PW-1:0] ms_cnt;
  logic          tick;
  logic [DEB-2:0] hist;
  logic [DEB-1:0] window;
  logic          deb_level;
  logic          qual_edge;
  logic [11:0]   ivl_cnt, cnt_inc;
  logic [2:0]    fill, fill_next;
  logic          clear_cnt, push, timeout, push_d;
  logic [11:0]   ivl_buf [4];
  logic [13:0]   sum;
  logic [11:0]   avg_now;
  logic [2:0]    zone_now, zone_code;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pulse_in;
      sync2 <= sync1;
    end
  end

  assign tick = (ms_cnt == PW'(CLK_PER_MS - 1));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) ms_cnt <= '0;
    else if (tick) ms_cnt <= '0;
    else ms_cnt <= ms_cnt + PW'(1);
  end

  // The window is the stored history plus this tick's sample; the level only
  // flips once every sample in it agrees.
  assign window    = {hist, sync2};
  assign qual_edge = tick && !deb_level && (&window);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hist      <= '0;
      deb_level <= 1'b0;
    end else if (tick) begin
      hist <= window[DEB-2:0];
      if (&window) deb_level <= 1'b1;
      else if (~|window) deb_level <= 1'b0;
    end
  end

  assign cnt_inc = (ivl_cnt == 12'hFFF) ? ivl_cnt : ivl_cnt + 12'd1;

  // Timeout wins over an edge landing on the same tick.
  always_comb begin
    state_next = state;
    fill_next  = fill;
    clear_cnt  = 1'b0;
    push       = 1'b0;
    timeout    = 1'b0;
    case (state)
      NO_SIGNAL: begin
        if (qual_edge) begin
          clear_cnt  = 1'b1;
          fill_next  = 3'd0;
          state_next = ACQUIRE;
        end
      end
      ACQUIRE, TRACK: begin
        if (tick && (cnt_inc >= 12'(NO_PULSE_MS))) begin
          timeout    = 1'b1;
          fill_next  = 3'd0;
          state_next = NO_SIGNAL;
        end else if (qual_edge && (cnt_inc >= 12'(MIN_MS))) begin
          push      = 1'b1;
          clear_cnt = 1'b1;
          if (state == ACQUIRE) begin
            fill_next = fill + 3'd1;
            if (fill == 3'd3) state_next = TRACK;
          end
        end
      end
      default: state_next = NO_SIGNAL;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state   <= NO_SIGNAL;
      fill    <= 3'd0;
      ivl_cnt <= 12'd0;
    end else begin
      state <= state_next;
      fill  <= fill_next;
      if (clear_cnt) ivl_cnt <= 12'd0;
      else if (tick) ivl_cnt <= cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < 4; i++) ivl_buf[i] <= 12'd0;
    end else if (push) begin
      ivl_buf[0] <= cnt_inc;
      for (int i = 1; i < 4; i++) ivl_buf[i] <= ivl_buf[i-1];
    end
  end

  assign sum = {2'b00, ivl_buf[0]} + {2'b00, ivl_buf[1]} +
               {2'b00, ivl_buf[2]} + {2'b00, ivl_buf[3]};
  assign avg_now = 12'(sum >> 2);

  always_comb begin
    zone_now = CODE_NORMAL;
    if (avg_now <= 12'(FAST_MS)) zone_now = CODE_FAST;
    else if (avg_now <= 12'(ELEV_MS)) zone_now = CODE_ELEV;
  end

  // Outputs follow the buffer one clk after a push and only while tracking,
  // so the code holds steady between beats.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      push_d       <= 1'b0;
      beat         <= 1'b0;
      zone_code    <= CODE_NONE;
      interval_avg <= 12'd0;
      tracking     <= 1'b0;
    end else begin
      push_d <= push;
      beat   <= push;
      if (timeout) begin
        zone_code    <= CODE_NONE;
        interval_avg <= 12'd0;
        tracking     <= 1'b0;
      end else if (push_d && (state == TRACK)) begin
        zone_code    <= zone_now;
        interval_avg <= avg_now;
        tracking     <= 1'b1;
      end
    end
  end

  assign {heartrate1, heartrate2, heartrate3} = zone_code;

endmodule

// File: tb/tb_heart_zone_encoder.sv
// Directed bench for heart_zone_encoder; 1 ms is shortened to 3 clks so the
// multi-second beat scenarios stay short.
module tb_heart_zone_encoder;

  localparam int CPM = 3;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        pulse_in;
  logic        heartrate1, heartrate2, heartrate3;
  logic        beat;
  logic [11:0] interval_avg;
  logic        tracking;
  logic [2:0]  code;

  int compared   = 0;
  int mismatched = 0;
  int beats_seen = 0;
  int beat_at;
  int trk_rise_at;

  heart_zone_encoder #(.CLK_PER_MS(CPM)) dut (
    .clk          (clk),
    .clr_n        (clr_n),
    .pulse_in     (pulse_in),
    .heartrate1   (heartrate1),
    .heartrate2   (heartrate2),
    .heartrate3   (heartrate3),
    .beat         (beat),
    .interval_avg (interval_avg),
    .tracking     (tracking)
  );

  assign code = {heartrate1, heartrate2, heartrate3};

  always #5 clk = ~clk;

  // One beat: high for w_ms, next rise p_ms after this one. Runs and ends at posedge+1.
  task automatic pulse(input int w_ms, input int p_ms);
    logic prev_trk;
    prev_trk    = tracking;
    beat_at     = -1;
    trk_rise_at = -1;
    pulse_in    = 1'b1;
    for (int i = 0; i < p_ms * CPM; i++) begin
      @(posedge clk);
      #1;
      if (i + 1 == w_ms * CPM) pulse_in = 1'b0;
      if (beat === 1'b1) begin
        beats_seen++;
        beat_at = i;
      end
      if (tracking === 1'b1 && prev_trk !== 1'b1 && trk_rise_at < 0) trk_rise_at = i;
      prev_trk = tracking;
    end
  endtask

  task automatic idle_ms(input int n_ms);
    for (int i = 0; i < n_ms * CPM; i++) begin
      @(posedge clk);
      #1;
      if (beat === 1'b1) beats_seen++;
    end
  endtask

  task automatic test_reset;
    clr_n    = 1'b0;
    pulse_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if ({code, beat, tracking, interval_avg} !== {3'b111, 1'b0, 1'b0, 12'd0}) begin
      mismatched++;
      $display("[TB] FAIL reset_values: code=%b beat=%b trk=%b avg=%0d, want 111 0 0 0",
               code, beat, tracking, interval_avg);
    end
    clr_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      idle_ms(100);
      compared++;
      if ({code, beat, tracking, interval_avg} !== {3'b111, 1'b0, 1'b0, 12'd0}) begin
        mismatched++;
        $display("[TB] FAIL reset_hold @%0dms: code=%b beat=%b trk=%b avg=%0d, want 111 0 0 0",
                 (k + 1) * 100, code, beat, tracking, interval_avg);
      end
    end
  endtask

  task automatic test_acquire;
    int b0;
    b0 = beats_seen;
    for (int k = 0; k < 4; k++) pulse(100, 800);
    compared++;
    if (beats_seen - b0 !== 3) begin
      mismatched++;
      $display("[TB] FAIL acquire_beats4: got %0d beats, want 3", beats_seen - b0);
    end
    compared++;
    if ({code, tracking, interval_avg} !== {3'b111, 1'b0, 12'd0}) begin
      mismatched++;
      $display("[TB] FAIL acquire_outputs: code=%b trk=%b avg=%0d, want 111 0 0",
               code, tracking, interval_avg);
    end
    pulse(100, 800);
    compared++;
    if (beats_seen - b0 !== 4) begin
      mismatched++;
      $display("[TB] FAIL acquire_beats5: got %0d beats, want 4", beats_seen - b0);
    end
    compared++;
    if (!(beat_at >= 0 && trk_rise_at == beat_at + 1)) begin
      mismatched++;
      $display("[TB] FAIL track_latency: beat at %0d, tracking rose at %0d, want beat+1",
               beat_at, trk_rise_at);
    end
    compared++;
    if ({code, tracking, interval_avg} !== {3'b001, 1'b1, 12'd800}) begin
      mismatched++;
      $display("[TB] FAIL track_800: code=%b trk=%b avg=%0d, want 001 1 800",
               code, tracking, interval_avg);
    end
  endtask

  task automatic test_artifact;
    int b0;
    b0 = beats_seen;
    pulse(100, 150);
    pulse(50, 650);
    compared++;
    if (beats_seen - b0 !== 1) begin
      mismatched++;
      $display("[TB] FAIL artifact_beats: got %0d beats, want 1", beats_seen - b0);
    end
    compared++;
    if ({code, interval_avg} !== {3'b001, 12'd800}) begin
      mismatched++;
      $display("[TB] FAIL artifact_avg: code=%b avg=%0d, want 001 800", code, interval_avg);
    end
    pulse(100, 600);
    compared++;
    if (beats_seen - b0 !== 2) begin
      mismatched++;
      $display("[TB] FAIL artifact_next_beats: got %0d beats, want 2", beats_seen - b0);
    end
    compared++;
    if ({code, interval_avg} !== {3'b001, 12'd800}) begin
      mismatched++;
      $display("[TB] FAIL artifact_next_avg: code=%b avg=%0d, want 001 800", code, interval_avg);
    end
  endtask

  task automatic test_zones;
    int          per_ms  [8] = '{600, 600, 600, 400, 400, 400, 400, 400};
    int          exp_avg [8] = '{750, 700, 650, 600, 550, 500, 450, 400};
    logic [2:0]  exp_code[8] = '{3'b001, 3'b001, 3'b011, 3'b011,
                                 3'b011, 3'b000, 3'b000, 3'b000};
    int b0;
    for (int k = 0; k < 8; k++) begin
      b0 = beats_seen;
      pulse(100, per_ms[k]);
      compared++;
      if (beats_seen - b0 !== 1 || code !== exp_code[k] || interval_avg !== 12'(exp_avg[k])) begin
        mismatched++;
        $display("[TB] FAIL zone_step%0d: beats=%0d code=%b avg=%0d, want 1 %b %0d",
                 k, beats_seen - b0, code, interval_avg, exp_code[k], exp_avg[k]);
      end
    end
  endtask

  task automatic test_glitch_timeout;
    int b0;
    b0 = beats_seen;
    pulse(2, 50);
    pulse(1, 50);
    compared++;
    if (beats_seen !== b0 || {code, interval_avg} !== {3'b000, 12'd400}) begin
      mismatched++;
      $display("[TB] FAIL glitch_reject: beats=%0d code=%b avg=%0d, want 0 000 400",
               beats_seen - b0, code, interval_avg);
    end
    idle_ms(1400);
    compared++;
    if ({code, tracking} !== {3'b000, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL pre_timeout: code=%b trk=%b, want 000 1", code, tracking);
    end
    idle_ms(150);
    compared++;
    if ({code, tracking, interval_avg} !== {3'b111, 1'b0, 12'd0}) begin
      mismatched++;
      $display("[TB] FAIL timeout: code=%b trk=%b avg=%0d, want 111 0 0",
               code, tracking, interval_avg);
    end
  endtask

  task automatic test_reset_mid_track;
    int b0;
    for (int k = 0; k < 5; k++) pulse(100, 400);
    compared++;
    if ({code, tracking, interval_avg} !== {3'b000, 1'b1, 12'd400}) begin
      mismatched++;
      $display("[TB] FAIL retrack_400: code=%b trk=%b avg=%0d, want 000 1 400",
               code, tracking, interval_avg);
    end
    #2 clr_n = 1'b0;
    #1;
    compared++;
    if ({code, beat, tracking, interval_avg} !== {3'b111, 1'b0, 1'b0, 12'd0}) begin
      mismatched++;
      $display("[TB] FAIL async_clear: code=%b beat=%b trk=%b avg=%0d, want 111 0 0 0",
               code, beat, tracking, interval_avg);
    end
    repeat (3) @(posedge clk);
    #1 clr_n = 1'b1;
    b0 = beats_seen;
    for (int k = 0; k < 4; k++) pulse(100, 400);
    compared++;
    if (beats_seen - b0 !== 3 || {code, tracking, interval_avg} !== {3'b111, 1'b0, 12'd0}) begin
      mismatched++;
      $display("[TB] FAIL post_reset_acquire: beats=%0d code=%b trk=%b avg=%0d, want 3 111 0 0",
               beats_seen - b0, code, tracking, interval_avg);
    end
    pulse(100, 400);
    compared++;
    if (beats_seen - b0 !== 4 || {code, tracking, interval_avg} !== {3'b000, 1'b1, 12'd400}) begin
      mismatched++;
      $display("[TB] FAIL post_reset_track: beats=%0d code=%b trk=%b avg=%0d, want 4 000 1 400",
               beats_seen - b0, code, tracking, interval_avg);
    end
  endtask

  initial begin
    test_reset;
    test_acquire;
    test_artifact;
    test_zones;
    test_glitch_timeout;
    test_reset_mid_track;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
